// File: rtl/que_arb_pkg.sv
// Shared types and width helpers for the queue-path request arbiter.
package que_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Bits needed to encode values 0..count-1, never less than one.
  function automatic int width_of(input int count);
    int w;
    w = 1;
    while ((1 << w) < count) w++;
    return w;
  endfunction

endpackage

// File: rtl/que_rr_arbiter_if.sv
// Request/grant bundle between the per-port queue request lines and the arbiter.
interface que_rr_arbiter_if #(
  parameter int NUM_REQ = 16
);
  import que_arb_pkg::*;

  localparam int SEL_W = width_of(NUM_REQ);

  logic [NUM_REQ-1:0] i_req;
  logic               i_release;
  logic               o_gnt_vld;
  logic [SEL_W-1:0]   o_gnt_sel;
  logic [NUM_REQ-1:0] o_gnt_onehot;
  logic               o_timeout;

  modport master (
    output i_req, i_release,
    input  o_gnt_vld, o_gnt_sel, o_gnt_onehot, o_timeout
  );

  modport slave (
    input  i_req, i_release,
    output o_gnt_vld, o_gnt_sel, o_gnt_onehot, o_timeout
  );

endinterface

// File: rtl/que_rr_arbiter_rr_prior_sel.sv
// First-active-bit search over N bits beginning at a start index, wrapping
// modulo N. Produces found flag, binary index and one-hot of the winner.
module rr_prior_sel #(
  parameter int N     = 16,
  parameter int SEL_W = 4
) (
  input  logic [N-1:0]     i_active,
  input  logic [SEL_W-1:0] i_start,
  output logic             o_found,
  output logic [SEL_W-1:0] o_idx,
  output logic [N-1:0]     o_onehot
);

  function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] start,
                                                input int offset);
    int sum;
    sum = int'(start) + offset;
    if (sum >= N) sum = sum - N;
    return SEL_W'(sum);
  endfunction

  // NOTE: every output gets a default before the loop so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    o_found  = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    // Walk from the farthest offset back to the start so the nearest hit wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (i_active[wrap_idx(i_start, k)]) begin
        o_found = 1'b1;
        o_idx   = wrap_idx(i_start, k);
      end
    end
    if (o_found) o_onehot[o_idx] = 1'b1;
  end

endmodule

// File: rtl/que_rr_arbiter.sv
// Clocked N-way queue arbiter: fixed or round-robin selection, grant held until
// release, request withdrawal or hold timeout, back-to-back re-arbitration.
module que_rr_arbiter
  import que_arb_pkg::*;
#(
  parameter int   NUM_REQ  = 16,
  parameter logic TARGET   = 1'b1,
  parameter logic RR_EN    = 1'b1,
  parameter int   MAX_HOLD = 0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  que_rr_arbiter_if.slave arb_if
);

  localparam int SEL_W  = width_of(NUM_REQ);
  localparam int HOLD_W = width_of(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  arb_state_e          r_state, w_nxt_state;
  logic [SEL_W-1:0]    r_sel, w_nxt_sel;
  logic [NUM_REQ-1:0]  r_onehot, w_nxt_onehot;
  logic [SEL_W-1:0]    r_rr_ptr, w_nxt_rr_ptr;
  logic [HOLD_W-1:0]   r_hold_cnt, w_nxt_hold_cnt;
  logic                r_timeout, w_nxt_timeout;

  logic [NUM_REQ-1:0]  w_active;
  logic [SEL_W-1:0]    w_start;
  logic                w_found;
  logic [SEL_W-1:0]    w_win_idx;
  logic [NUM_REQ-1:0]  w_win_onehot;
  logic                w_release;
  logic                w_hold_expire;

  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
    return (int'(idx) == NUM_REQ - 1) ? '0 : idx + SEL_W'(1);
  endfunction

  assign w_active = ~(arb_if.i_req ^ {NUM_REQ{TARGET}});

  // While a grant is held, the search already uses the post-exit pointer so a
  // release re-arbitrates in the same cycle with the releaser at lowest priority.
  assign w_start = (RR_EN == 1'b0)    ? '0 :
                   (r_state == GRANT) ? next_idx(r_sel) : r_rr_ptr;

  rr_prior_sel #(
    .N     (NUM_REQ),
    .SEL_W (SEL_W)
  ) u_prior_sel (
    .i_active (w_active),
    .i_start  (w_start),
    .o_found  (w_found),
    .o_idx    (w_win_idx),
    .o_onehot (w_win_onehot)
  );

  assign w_release     = arb_if.i_release || !w_active[r_sel];
  assign w_hold_expire = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST);

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_sel      = r_sel;
    w_nxt_onehot   = r_onehot;
    w_nxt_rr_ptr   = r_rr_ptr;
    w_nxt_hold_cnt = r_hold_cnt;
    w_nxt_timeout  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_nxt_state    = GRANT;
          w_nxt_sel      = w_win_idx;
          w_nxt_onehot   = w_win_onehot;
          w_nxt_hold_cnt = '0;
        end
      end
      GRANT: begin
        if (w_release || w_hold_expire) begin
          w_nxt_rr_ptr   = next_idx(r_sel);
          w_nxt_timeout  = !w_release;
          w_nxt_hold_cnt = '0;
          w_nxt_state    = w_found ? GRANT : IDLE;
          w_nxt_sel      = w_found ? w_win_idx : '0;
          w_nxt_onehot   = w_found ? w_win_onehot : '0;
        end else if ((MAX_HOLD != 0) && (r_hold_cnt != HOLD_LAST)) begin
          w_nxt_hold_cnt = r_hold_cnt + HOLD_W'(1);
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_sel      <= '0;
      r_onehot   <= '0;
      r_rr_ptr   <= '0;
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_sel      <= w_nxt_sel;
      r_onehot   <= w_nxt_onehot;
      r_rr_ptr   <= w_nxt_rr_ptr;
      r_hold_cnt <= w_nxt_hold_cnt;
      r_timeout  <= w_nxt_timeout;
    end
  end

  assign arb_if.o_gnt_vld    = (r_state == GRANT);
  assign arb_if.o_gnt_sel    = r_sel;
  assign arb_if.o_gnt_onehot = r_onehot;
  assign arb_if.o_timeout    = r_timeout;

endmodule

// File: tb/tb_que_rr_arbiter.sv
// Scoreboard bench: directed steps push hand-computed expected outputs, a
// monitor pops and compares one entry per clock for each of three DUT configs.
module tb_que_rr_arbiter;

  typedef struct packed {
    logic        vld;
    logic [3:0]  sel;
    logic [15:0] oh;
    logic        to;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_rr = 1'b1;
  logic rst_fx = 1'b1;
  logic rst_to = 1'b1;

  que_rr_arbiter_if #(.NUM_REQ(16)) bus_rr ();
  que_rr_arbiter_if #(.NUM_REQ(16)) bus_fx ();
  que_rr_arbiter_if #(.NUM_REQ(16)) bus_to ();

  que_rr_arbiter #(.NUM_REQ(16), .TARGET(1'b1), .RR_EN(1'b1), .MAX_HOLD(0)) u_rr (
    .i_clk(clk), .i_rst(rst_rr), .arb_if(bus_rr));
  que_rr_arbiter #(.NUM_REQ(16), .TARGET(1'b1), .RR_EN(1'b0), .MAX_HOLD(0)) u_fx (
    .i_clk(clk), .i_rst(rst_fx), .arb_if(bus_fx));
  que_rr_arbiter #(.NUM_REQ(16), .TARGET(1'b1), .RR_EN(1'b1), .MAX_HOLD(4)) u_to (
    .i_clk(clk), .i_rst(rst_to), .arb_if(bus_to));

  exp_t q_rr[$];
  exp_t q_fx[$];
  exp_t q_to[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_rr = 0, n_fx = 0, n_to = 0;

  task automatic compare(input string tag, input int n, input exp_t exp, input exp_t act);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s#%0d: got vld=%0b sel=%0d oh=%h to=%0b, expected vld=%0b sel=%0d oh=%h to=%0b",
               tag, n, act.vld, act.sel, act.oh, act.to, exp.vld, exp.sel, exp.oh, exp.to);
    end
  endtask

  // Monitor: one comparison per clock for every DUT with a pending expectation.
  initial begin
    exp_t act;
    forever begin
      @(posedge clk);
      #1;
      if (q_rr.size() > 0) begin
        act = {bus_rr.o_gnt_vld, bus_rr.o_gnt_sel, bus_rr.o_gnt_onehot, bus_rr.o_timeout};
        compare("rr", n_rr++, q_rr.pop_front(), act);
      end
      if (q_fx.size() > 0) begin
        act = {bus_fx.o_gnt_vld, bus_fx.o_gnt_sel, bus_fx.o_gnt_onehot, bus_fx.o_timeout};
        compare("fx", n_fx++, q_fx.pop_front(), act);
      end
      if (q_to.size() > 0) begin
        act = {bus_to.o_gnt_vld, bus_to.o_gnt_sel, bus_to.o_gnt_onehot, bus_to.o_timeout};
        compare("to", n_to++, q_to.pop_front(), act);
      end
    end
  end

  // Drive one cycle of inputs on DUT d and queue the outputs expected after the next edge.
  task automatic step(input int d, input logic rst, input logic [15:0] req, input logic rel,
                      input logic vld, input int sel, input logic to);
    exp_t e;
    @(negedge clk);
    e.vld = vld;
    e.sel = 4'(sel);
    e.oh  = vld ? (16'd1 << sel) : 16'd0;
    e.to  = to;
    case (d)
      0: begin rst_rr = rst; bus_rr.i_req = req; bus_rr.i_release = rel; q_rr.push_back(e); end
      1: begin rst_fx = rst; bus_fx.i_req = req; bus_fx.i_release = rel; q_fx.push_back(e); end
      default: begin rst_to = rst; bus_to.i_req = req; bus_to.i_release = rel; q_to.push_back(e); end
    endcase
  endtask

  int rr_sel_tab[12] = '{0, 0, 5, 5, 5, 10, 10, 10, 15, 15, 15, 0};

  initial begin
    bus_rr.i_req = '0; bus_rr.i_release = 1'b0;
    bus_fx.i_req = '0; bus_fx.i_release = 1'b0;
    bus_to.i_req = '0; bus_to.i_release = 1'b0;

    // Round-robin: reset with all requests, then rotation over 16'h8421.
    step(0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 0, 1'b0);
    step(0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 0, 1'b0);
    step(0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 12; i++)
      step(0, 1'b0, 16'h8421, (i % 3) == 2, 1'b1, rr_sel_tab[i], 1'b0);
    // Withdrawal: winner 0 drops -> 2; winner 2 drops -> 5; all drop -> idle.
    step(0, 1'b0, 16'h0024, 1'b0, 1'b1, 2, 1'b0);
    step(0, 1'b0, 16'h0020, 1'b0, 1'b1, 5, 1'b0);
    step(0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
    step(0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    // Pointer to 9 via grant/release of 8, then reset mid-grant.
    step(0, 1'b0, 16'h0100, 1'b0, 1'b1, 8, 1'b0);
    step(0, 1'b0, 16'h0100, 1'b1, 1'b1, 8, 1'b0);
    step(0, 1'b1, 16'h0100, 1'b0, 1'b0, 0, 1'b0);
    step(0, 1'b0, 16'h0202, 1'b0, 1'b1, 1, 1'b0);
    step(0, 1'b0, 16'h0202, 1'b1, 1'b1, 9, 1'b0);

    // Fixed priority: lowest index always wins.
    step(1, 1'b1, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
    step(1, 1'b0, 16'h00F0, 1'b0, 1'b1, 4, 1'b0);
    step(1, 1'b0, 16'h00F0, 1'b1, 1'b1, 4, 1'b0);
    step(1, 1'b0, 16'h00F0, 1'b0, 1'b1, 4, 1'b0);
    step(1, 1'b0, 16'h00F0, 1'b1, 1'b1, 4, 1'b0);
    step(1, 1'b0, 16'h00E0, 1'b0, 1'b1, 5, 1'b0);
    step(1, 1'b0, 16'h00E1, 1'b0, 1'b1, 5, 1'b0);
    step(1, 1'b0, 16'h00E1, 1'b1, 1'b1, 0, 1'b0);

    // Hold timeout with MAX_HOLD = 4.
    step(2, 1'b1, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
    step(2, 1'b0, 16'h0008, 1'b0, 1'b1, 3, 1'b0);
    step(2, 1'b0, 16'h0008, 1'b0, 1'b1, 3, 1'b0);
    step(2, 1'b0, 16'h0008, 1'b0, 1'b1, 3, 1'b0);
    step(2, 1'b0, 16'h0008, 1'b0, 1'b1, 3, 1'b0);
    step(2, 1'b0, 16'h0008, 1'b0, 1'b1, 3, 1'b1);
    step(2, 1'b0, 16'h0008, 1'b0, 1'b1, 3, 1'b0);
    step(2, 1'b0, 16'h0008, 1'b0, 1'b1, 3, 1'b0);
    step(2, 1'b0, 16'h0008, 1'b0, 1'b1, 3, 1'b0);
    step(2, 1'b0, 16'h0008, 1'b1, 1'b1, 3, 1'b0);
    step(2, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
    // Timeout hands over in rotation: 4 held, expires, 3 wins next.
    step(2, 1'b0, 16'h0018, 1'b0, 1'b1, 4, 1'b0);
    step(2, 1'b0, 16'h0018, 1'b0, 1'b1, 4, 1'b0);
    step(2, 1'b0, 16'h0018, 1'b0, 1'b1, 4, 1'b0);
    step(2, 1'b0, 16'h0018, 1'b0, 1'b1, 4, 1'b0);
    step(2, 1'b0, 16'h0018, 1'b0, 1'b1, 3, 1'b1);

    for (int i = 0; i < 20; i++) begin
      if (q_rr.size() + q_fx.size() + q_to.size() == 0) break;
      @(posedge clk);
    end
    #2;
    checks++;
    if (q_rr.size() + q_fx.size() + q_to.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations still pending, expected 0",
               q_rr.size() + q_fx.size() + q_to.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
